// File: rtl/router_pkg.sv
// router_pkg: shared router types and constants.
// Used by the per-port collector and its FIFO.
package router_pkg;

  localparam int COLL_DATA_W = 8;
  localparam int NUM_PORTS   = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } coll_entry_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    RECV,
    DROP
  } coll_state_t;

endpackage

// File: rtl/router_sync_fifo.sv
// router_sync_fifo: show-ahead synchronous FIFO.
// A push while full is accepted only with a same-cycle pop.
module router_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/router_port_collector.sv
// router_port_collector: deserialises one router output port
// into a FIFO-buffered valid/ready byte stream with status.
module router_port_collector
  import router_pkg::*;
#(
  parameter int DATA_W     = COLL_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameo_n,
  input  logic              valido_n,
  input  logic              dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  pkt_cnt
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] TOP_BIT = BW'(DATA_W - 1);

  coll_state_t       state;
  coll_state_t       state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] byte_nxt;
  logic [BW-1:0]     bit_cnt;
  logic              bit_en;
  logic              eop;
  logic              byte_full;
  logic              partial;
  logic              no_bit;
  logic              push_req;
  logic              pop;
  logic              overflow;
  logic              drop_byte;
  logic              bad;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:    if (frameo_n) state_nxt = IDLE;
      IDLE:    if (!frameo_n) state_nxt = RECV;
      RECV: begin
        if (eop)           state_nxt = IDLE;
        else if (overflow) state_nxt = DROP;
      end
      DROP:    if (frameo_n) state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  // Packet end is only seen once a frame is open (RECV/DROP).
  always_comb begin
    bit_en    = !valido_n &&
                ((state == RECV) || (state == DROP) ||
                 ((state == IDLE) && !frameo_n));
    eop       = frameo_n && ((state == RECV) || (state == DROP));
    byte_full = bit_en && (bit_cnt == TOP_BIT);
    partial   = eop && ((bit_en && !byte_full) ||
                        (!bit_en && (bit_cnt != '0)));
    no_bit    = eop && !bit_en && (bit_cnt == '0);
    push_req  = (state != DROP) && (byte_full || partial);
    overflow  = push_req && fifo_full && !pop;
    drop_byte = overflow || ((state == DROP) && byte_full);
    bad       = partial || no_bit || overflow || (state == DROP);
  end

  always_comb begin
    byte_nxt = shreg;
    if (bit_en) byte_nxt[bit_cnt] = dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (eop) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (bit_en) begin
        shreg   <= byte_full ? '0 : byte_nxt;
        bit_cnt <= bit_cnt + BW'(1);
      end
      pkt_done <= eop;
      pkt_err  <= eop && bad;
      if (eop && (pkt_cnt != '1))
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (drop_byte && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign pop     = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign m_last  = m_valid && fifo_rdata[DATA_W];

  router_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata ({frameo_n, byte_nxt}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_router_port_collector.sv
// tb_router_port_collector: directed tests for the port collector
// built with a 4-entry FIFO so overflow is easy to reach.
module tb_router_port_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frameo_n = 1'b1;
  logic        valido_n = 1'b1;
  logic        dout = 1'b0;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        pkt_done;
  logic        pkt_err;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] beats[$];
  int done_seen = 0;
  int err_seen = 0;
  int stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;
  bit tog_ready = 1'b0;

  router_port_collector #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .frameo_n (frameo_n),
    .valido_n (valido_n),
    .dout     (dout),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .drop_cnt (drop_cnt),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_beat)))
        stall_bad++;
      if (m_valid && m_ready) beats.push_back({m_last, m_data});
      if (pkt_done) done_seen++;
      if (pkt_err) err_seen++;
      prev_stall = m_valid && !m_ready;
      prev_beat = {m_last, m_data};
    end
  end

  task automatic send_bit(input logic f, input logic v, input logic d);
    @(posedge clk);
    #1;
    frameo_n = f;
    valido_n = v;
    dout = d;
    if (tog_ready) m_ready = !m_ready;
  endtask

  task automatic send_pkt(input logic [63:0] vec, input int n,
                          input bit gaps, input bit tail);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) send_bit(1'b0, 1'b1, 1'b0);
      send_bit(i == n - 1, 1'b0, vec[i]);
    end
    if (tail) send_bit(1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_valid got %0b want 0", m_valid);
    end
    n_cmp++;
    if (m_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_m_data got %h want 00", m_data);
    end
    n_cmp++;
    if (m_last !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_last got %0b want 0", m_last);
    end
    n_cmp++;
    if ({pkt_done, pkt_err} !== 2'b00) begin
      n_bad++; $display("FAIL reset_pulses got %b want 00", {pkt_done, pkt_err});
    end
    n_cmp++;
    if (drop_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt);
    end
  endtask

  task automatic test_two_bytes(input string nm, input bit gaps, input int cnt);
    int b0, d0, e0;
    b0 = beats.size(); d0 = done_seen; e0 = err_seen;
    m_ready = 1'b1;
    send_pkt(64'h3CA5, 16, gaps, 1'b1);
    idle(6);
    n_cmp++;
    if (beats.size() - b0 != 2) begin
      n_bad++; $display("FAIL %s_beats got %0d want 2", nm, beats.size() - b0);
    end
    if (beats.size() >= b0 + 2) begin
      n_cmp++;
      if (beats[b0] !== 9'h0A5) begin
        n_bad++; $display("FAIL %s_beat0 got %h want 0a5", nm, beats[b0]);
      end
      n_cmp++;
      if (beats[b0+1] !== 9'h13C) begin
        n_bad++; $display("FAIL %s_beat1 got %h want 13c", nm, beats[b0+1]);
      end
    end
    n_cmp++;
    if (done_seen - d0 != 1 || err_seen - e0 != 0) begin
      n_bad++;
      $display("FAIL %s_status got done=%0d err=%0d want 1/0",
               nm, done_seen - d0, err_seen - e0);
    end
    n_cmp++;
    if (pkt_cnt !== 16'(cnt)) begin
      n_bad++; $display("FAIL %s_pkt_cnt got %0d want %0d", nm, pkt_cnt, cnt);
    end
  endtask

  task automatic test_partial();
    int b0, d0, e0;
    b0 = beats.size(); d0 = done_seen; e0 = err_seen;
    send_pkt(64'hABC, 12, 1'b0, 1'b1);
    idle(6);
    n_cmp++;
    if (beats.size() - b0 != 2) begin
      n_bad++; $display("FAIL partial_beats got %0d want 2", beats.size() - b0);
    end
    if (beats.size() >= b0 + 2) begin
      n_cmp++;
      if (beats[b0] !== 9'h0BC) begin
        n_bad++; $display("FAIL partial_beat0 got %h want 0bc", beats[b0]);
      end
      n_cmp++;
      if (beats[b0+1] !== 9'h10A) begin
        n_bad++; $display("FAIL partial_beat1 got %h want 10a", beats[b0+1]);
      end
    end
    n_cmp++;
    if (done_seen - d0 != 1 || err_seen - e0 != 1) begin
      n_bad++;
      $display("FAIL partial_status got done=%0d err=%0d want 1/1",
               done_seen - d0, err_seen - e0);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd2) begin
      n_bad++; $display("FAIL partial_pkt_cnt got %0d want 2", pkt_cnt);
    end
  endtask

  task automatic test_overflow();
    int b0, d0, e0;
    logic [8:0] exp;
    b0 = beats.size(); d0 = done_seen; e0 = err_seen;
    @(posedge clk); #1; m_ready = 1'b0;
    send_pkt(64'h0000_0605_0403_0201, 48, 1'b0, 1'b1);
    idle(4);
    n_cmp++;
    if (drop_cnt !== 16'd2) begin
      n_bad++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt);
    end
    n_cmp++;
    if (done_seen - d0 != 1 || err_seen - e0 != 1) begin
      n_bad++;
      $display("FAIL ovf_status got done=%0d err=%0d want 1/1",
               done_seen - d0, err_seen - e0);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || beats.size() != b0) begin
      n_bad++;
      $display("FAIL ovf_held got valid=%0b beats=%0d want 1/0",
               m_valid, beats.size() - b0);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    idle(8);
    n_cmp++;
    if (beats.size() - b0 != 4) begin
      n_bad++; $display("FAIL ovf_drain got %0d want 4", beats.size() - b0);
    end
    for (int k = 0; k < 4; k++) begin
      if (beats.size() > b0 + k) begin
        exp = 9'(k + 1);
        n_cmp++;
        if (beats[b0+k] !== exp) begin
          n_bad++; $display("FAIL ovf_beat%0d got %h want %h", k, beats[b0+k], exp);
        end
      end
    end
    n_cmp++;
    if (m_valid !== 1'b0 || pkt_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL ovf_end got valid=%0b cnt=%0d want 0/4", m_valid, pkt_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int b0, d0, e0;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, i[0]);
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    b0 = beats.size(); d0 = done_seen; e0 = err_seen;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0, i[1]);
    send_bit(1'b1, 1'b0, 1'b1);
    idle(4);
    n_cmp++;
    if (beats.size() != b0 || done_seen != d0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet got beats=%0d done=%0d want 0/0",
               beats.size() - b0, done_seen - d0);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset_cnt got pkt=%0d drop=%0d want 0/0", pkt_cnt, drop_cnt);
    end
    send_pkt(64'h5A, 8, 1'b0, 1'b1);
    idle(4);
    n_cmp++;
    if (beats.size() - b0 != 1) begin
      n_bad++; $display("FAIL mid_reset_beats got %0d want 1", beats.size() - b0);
    end
    if (beats.size() > b0) begin
      n_cmp++;
      if (beats[b0] !== 9'h15A) begin
        n_bad++; $display("FAIL mid_reset_beat got %h want 15a", beats[b0]);
      end
    end
    n_cmp++;
    if (pkt_cnt !== 16'd1 || err_seen != e0) begin
      n_bad++;
      $display("FAIL mid_reset_pkt got cnt=%0d err=%0d want 1/0",
               pkt_cnt, err_seen - e0);
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, e0, s0;
    logic [8:0] exp [3];
    exp[0] = 9'h011; exp[1] = 9'h122; exp[2] = 9'h133;
    do_reset();
    b0 = beats.size(); d0 = done_seen; e0 = err_seen; s0 = stall_bad;
    tog_ready = 1'b1;
    send_pkt(64'h2211, 16, 1'b0, 1'b0);
    send_pkt(64'h33, 8, 1'b0, 1'b1);
    idle(8);
    tog_ready = 1'b0;
    @(posedge clk); #1; m_ready = 1'b1;
    idle(2);
    n_cmp++;
    if (beats.size() - b0 != 3) begin
      n_bad++; $display("FAIL b2b_beats got %0d want 3", beats.size() - b0);
    end
    for (int k = 0; k < 3; k++) begin
      if (beats.size() > b0 + k) begin
        n_cmp++;
        if (beats[b0+k] !== exp[k]) begin
          n_bad++; $display("FAIL b2b_beat%0d got %h want %h", k, beats[b0+k], exp[k]);
        end
      end
    end
    n_cmp++;
    if (stall_bad != s0) begin
      n_bad++; $display("FAIL b2b_stall got %0d changes want 0", stall_bad - s0);
    end
    n_cmp++;
    if (done_seen - d0 != 2 || err_seen - e0 != 0) begin
      n_bad++;
      $display("FAIL b2b_status got done=%0d err=%0d want 2/0",
               done_seen - d0, err_seen - e0);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd2) begin
      n_bad++; $display("FAIL b2b_pkt_cnt got %0d want 2", pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes("basic", 1'b0, 1);
    test_partial();
    test_two_bytes("gapped", 1'b1, 3);
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
